// File: rtl/noc_route_sched_pkg.sv
// Shared types and default sizing for the NI initiator route scheduler.
// The outstanding counter width is derived from the largest supported in-flight limit.
package noc_route_sched_pkg;

  localparam int DEF_PATH_W          = 7;
  localparam int DEF_TGT_W           = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int OUTSTANDING_LIMIT   = 15;

  function automatic int cnt_w_for(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_w_for(OUTSTANDING_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/outstanding_counter.sv
// Saturating up/down count of in-flight transactions; a decrement at zero is dropped
// and simultaneous increment/decrement leave the count unchanged.
module outstanding_counter
  import noc_route_sched_pkg::*;
#(
  parameter int MAX   = DEF_MAX_OUTSTANDING,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             is_zero
);

  logic dec_eff;

  assign at_max  = (count == CNT_W'(MAX));
  assign is_zero = (count == '0);
  assign dec_eff = dec && !is_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec_eff && !at_max) begin
      count <= count + CNT_W'(1);
    end else if (dec_eff && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ni_initiator_route_scheduler.sv
// Sequences routing-LUT lookups for master requests, issues packetizer headers in order
// per target, and turns decode failures into error-response requests.
module ni_initiator_route_scheduler
  import noc_route_sched_pkg::*;
#(
  parameter int PATH_W          = DEF_PATH_W,
  parameter int TGT_W           = DEF_TGT_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req_valid,
  input  logic [31:0]       m_req_addr,
  output logic              m_req_ready,
  output logic [31:0]       lut_address,
  input  logic [PATH_W-1:0] lut_path,
  input  logic [TGT_W-1:0]  lut_target,
  input  logic              lut_failed,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [PATH_W-1:0] hdr_path,
  output logic [TGT_W-1:0]  hdr_target,
  output logic [31:0]       hdr_addr,
  input  logic              resp_done,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [CNT_W-1:0]  outstanding,
  output logic              busy
);

  state_t            state;
  logic [31:0]       addr_q;
  logic [PATH_W-1:0] path_q;
  logic [TGT_W-1:0]  tgt_q;
  logic [TGT_W-1:0]  last_tgt_q;
  logic              fail_q;
  logic              at_max;
  logic              is_zero;
  logic              hdr_fire;

  assign lut_address = addr_q;
  assign hdr_addr    = addr_q;
  assign hdr_path    = path_q;
  assign hdr_target  = tgt_q;
  assign hdr_fire    = hdr_valid && hdr_ready;
  assign busy        = (state != ST_IDLE) || !is_zero;

  outstanding_counter #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_outstanding (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (hdr_fire),
    .dec     (resp_done),
    .count   (outstanding),
    .at_max  (at_max),
    .is_zero (is_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      path_q      <= '0;
      tgt_q       <= '0;
      last_tgt_q  <= '0;
      fail_q      <= 1'b0;
      m_req_ready <= 1'b1;
      hdr_valid   <= 1'b0;
      err_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m_req_valid) begin
            addr_q      <= m_req_addr;
            m_req_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          path_q <= lut_path;
          tgt_q  <= lut_target;
          fail_q <= lut_failed;
          if (lut_failed) begin
            err_valid <= 1'b1;
            state     <= ST_ERR;
          end else if ((!is_zero && lut_target != last_tgt_q) || at_max) begin
            state <= ST_WAIT;
          end else begin
            hdr_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          // Judged on the registered count, so a resp_done this cycle opens the gate next cycle.
          if ((tgt_q == last_tgt_q && !at_max) || is_zero) begin
            hdr_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hdr_ready) begin
            hdr_valid   <= 1'b0;
            last_tgt_q  <= tgt_q;
            m_req_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_ERR: begin
          // fail_q is always set here; the guard only lets a corrupted state escape.
          if (err_ready || !fail_q) begin
            err_valid   <= 1'b0;
            fail_q      <= 1'b0;
            m_req_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          hdr_valid   <= 1'b0;
          err_valid   <= 1'b0;
          m_req_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ni_initiator_route_scheduler.sv
// Directed bench for the route scheduler with a behavioural routing LUT beside the DUT.
module tb_ni_initiator_route_scheduler;

  logic        clk;
  logic        rst_n;
  logic        m_req_valid;
  logic [31:0] m_req_addr;
  logic        m_req_ready;
  logic [31:0] lut_address;
  logic [6:0]  lut_path;
  logic [3:0]  lut_target;
  logic        lut_failed;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [6:0]  hdr_path;
  logic [3:0]  hdr_target;
  logic [31:0] hdr_addr;
  logic        resp_done;
  logic        err_valid;
  logic        err_ready;
  logic [3:0]  outstanding;
  logic        busy;

  int errors = 0;
  int checks = 0;

  ni_initiator_route_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req_valid (m_req_valid),
    .m_req_addr  (m_req_addr),
    .m_req_ready (m_req_ready),
    .lut_address (lut_address),
    .lut_path    (lut_path),
    .lut_target  (lut_target),
    .lut_failed  (lut_failed),
    .hdr_valid   (hdr_valid),
    .hdr_ready   (hdr_ready),
    .hdr_path    (hdr_path),
    .hdr_target  (hdr_target),
    .hdr_addr    (hdr_addr),
    .resp_done   (resp_done),
    .err_valid   (err_valid),
    .err_ready   (err_ready),
    .outstanding (outstanding),
    .busy        (busy)
  );

  // Cluster routing LUT as generated for this NI.
  always_comb begin
    lut_path   = 7'b0;
    lut_target = 4'h0;
    lut_failed = 1'b1;
    if (lut_address >= 32'h1a00_0000 && lut_address <= 32'h1fff_fffe) begin
      lut_path   = 7'b0000001;
      lut_target = 4'hc;
      lut_failed = 1'b0;
    end else if (lut_address >= 32'h1000_0000 && lut_address <= 32'h103f_fffe) begin
      lut_path   = 7'b0000010;
      lut_target = 4'h1;
      lut_failed = 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the DECODE cycle (cycle 1).
  task automatic send_req(input logic [31:0] a);
    m_req_valid = 1'b1;
    m_req_addr  = a;
    step();
    m_req_valid = 1'b0;
  endtask

  task automatic pulse_resp();
    resp_done = 1'b1;
    step();
    resp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_req_valid = 1'b0; m_req_addr = '0; hdr_ready = 1'b0;
    resp_done = 1'b0; err_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL reset_m_req_ready: got %0b want 1", m_req_ready); end
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %0b want 0", hdr_valid); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %0b want 0", err_valid); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single();
    hdr_ready = 1'b1;
    send_req(32'h1a00_0000);
    checks++; if (hdr_valid !== 1'b0 || m_req_ready !== 1'b0) begin errors++; $display("FAIL single_cycle1: hdr_valid=%0b m_req_ready=%0b want 0/0", hdr_valid, m_req_ready); end
    checks++; if (lut_address !== 32'h1a00_0000) begin errors++; $display("FAIL single_lut_address: got %h want 1a000000", lut_address); end
    step();
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL single_hdr_valid_c2: got %0b want 1", hdr_valid); end
    checks++; if (hdr_path !== 7'b0000001 || hdr_target !== 4'hc || hdr_addr !== 32'h1a00_0000) begin errors++; $display("FAIL single_hdr_fields: path=%b tgt=%h addr=%h want 0000001/c/1a000000", hdr_path, hdr_target, hdr_addr); end
    step();
    checks++; if (outstanding !== 4'd1 || hdr_valid !== 1'b0 || m_req_ready !== 1'b1) begin errors++; $display("FAIL single_after_hs: out=%0d hdr_valid=%0b ready=%0b want 1/0/1", outstanding, hdr_valid, m_req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_inflight: got %0b want 1", busy); end
    pulse_resp();
    checks++; if (outstanding !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain: out=%0d busy=%0b want 0/0", outstanding, busy); end
  endtask

  task automatic test_error();
    hdr_ready = 1'b0;
    err_ready = 1'b0;
    send_req(32'h2000_0000);
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL err_cycle1: got %0b want 0", err_valid); end
    step();
    checks++; if (err_valid !== 1'b1 || hdr_valid !== 1'b0) begin errors++; $display("FAIL err_cycle2: err_valid=%0b hdr_valid=%0b want 1/0", err_valid, hdr_valid); end
    step(); step();
    checks++; if (err_valid !== 1'b1 || m_req_ready !== 1'b0 || outstanding !== 4'd0) begin errors++; $display("FAIL err_hold: err_valid=%0b ready=%0b out=%0d want 1/0/0", err_valid, m_req_ready, outstanding); end
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    checks++; if (err_valid !== 1'b0 || m_req_ready !== 1'b1 || outstanding !== 4'd0) begin errors++; $display("FAIL err_release: err_valid=%0b ready=%0b out=%0d want 0/1/0", err_valid, m_req_ready, outstanding); end
    send_req(32'h1fff_ffff);
    step();
    checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL err_boundary_1fffffff: got %0b want 1", err_valid); end
    err_ready = 1'b1;
    step();
    err_ready = 1'b0;
    hdr_ready = 1'b1;
    send_req(32'h1fff_fffe);
    step();
    checks++; if (hdr_valid !== 1'b1 || hdr_target !== 4'hc) begin errors++; $display("FAIL inrange_1ffffffe: hdr_valid=%0b tgt=%h want 1/c", hdr_valid, hdr_target); end
    step();
    pulse_resp();
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL err_never_counted: out=%0d want 0", outstanding); end
  endtask

  task automatic test_target_switch();
    hdr_ready = 1'b1;
    send_req(32'h1a00_0000);
    step(); step();
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL switch_first: out=%0d want 1", outstanding); end
    send_req(32'h1000_0000);
    step(); step(); step();
    checks++; if (hdr_valid !== 1'b0 || m_req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL switch_wait: hdr_valid=%0b ready=%0b busy=%0b want 0/0/1", hdr_valid, m_req_ready, busy); end
    pulse_resp();
    checks++; if (outstanding !== 4'd0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL switch_count0: out=%0d hdr_valid=%0b want 0/0", outstanding, hdr_valid); end
    step();
    checks++; if (hdr_valid !== 1'b1 || hdr_target !== 4'h1 || hdr_path !== 7'b0000010) begin errors++; $display("FAIL switch_issue: hdr_valid=%0b tgt=%h path=%b want 1/1/0000010", hdr_valid, hdr_target, hdr_path); end
    step();
    checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL switch_after: out=%0d want 1", outstanding); end
    pulse_resp();
  endtask

  task automatic test_same_target_limit();
    hdr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_req(32'h1000_0000);
      step();
      checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL limit_hdr_%0d: got %0b want 1", i, hdr_valid); end
      step();
      checks++; if (outstanding !== 4'(i + 1)) begin errors++; $display("FAIL limit_count_%0d: got %0d want %0d", i, outstanding, i + 1); end
    end
    send_req(32'h1000_0000);
    step(); step(); step();
    checks++; if (hdr_valid !== 1'b0 || m_req_ready !== 1'b0 || outstanding !== 4'd4) begin errors++; $display("FAIL limit_fifth_held: hdr_valid=%0b ready=%0b out=%0d want 0/0/4", hdr_valid, m_req_ready, outstanding); end
    pulse_resp();
    checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL limit_after_resp: out=%0d want 3", outstanding); end
    step();
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL limit_fifth_issue: got %0b want 1", hdr_valid); end
    step();
    checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL limit_back_to_4: out=%0d want 4", outstanding); end
  endtask

  task automatic test_coincident();
    pulse_resp();
    pulse_resp();
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL coinc_pre: out=%0d want 2", outstanding); end
    hdr_ready = 1'b1;
    send_req(32'h1000_0000);
    step();
    resp_done = 1'b1;
    step();
    resp_done = 1'b0;
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL coinc_hs_resp: out=%0d want 2", outstanding); end
    pulse_resp();
    pulse_resp();
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL coinc_drain: out=%0d want 0", outstanding); end
    pulse_resp();
    checks++; if (outstanding !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL spurious_resp: out=%0d busy=%0b want 0/0", outstanding, busy); end
  endtask

  task automatic test_reset_mid();
    hdr_ready = 1'b1;
    send_req(32'h1a00_0000);
    step(); step();
    hdr_ready = 1'b0;
    send_req(32'h1a00_0000);
    step(); step();
    checks++; if (hdr_valid !== 1'b1 || hdr_target !== 4'hc || outstanding !== 4'd1) begin errors++; $display("FAIL midrst_hold: hdr_valid=%0b tgt=%h out=%0d want 1/c/1", hdr_valid, hdr_target, outstanding); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hdr_valid !== 1'b0 || outstanding !== 4'd0) begin errors++; $display("FAIL midrst_async: hdr_valid=%0b out=%0d want 0/0", hdr_valid, outstanding); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (m_req_ready !== 1'b1 || busy !== 1'b0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL midrst_release: ready=%0b busy=%0b hdr_valid=%0b want 1/0/0", m_req_ready, busy, hdr_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_error();
    test_target_switch();
    test_same_target_limit();
    test_coincident();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
